// File: rtl/bus_rr_scheduler.sv
// Round-robin bus sequencer: grants one device FIFO at a time, pops its head
// packet and routes it to the destination FIFO(s) named by the packet's ID byte.
module bus_rr_scheduler #(
  parameter int drvrs     = 4,
  parameter int BITS      = 16,
  parameter int broadcast = 255,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*BITS-1:0]      D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*BITS-1:0]      D_push,
  output logic                       busy,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int ID_W = $clog2(drvrs);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ROUTE = 2'd2;
  localparam logic [1:0] PUSH  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [BITS-1:0]  pkt_q, pkt_d;
  logic [drvrs-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic             arb_found;
  logic [ID_W-1:0]  arb_id;
  logic [ID_W-1:0]  arb_idx;
  logic [7:0]       dest;
  logic [drvrs-1:0] route_mask;
  logic             route_ok;
  logic [BITS-1:0]  lane [drvrs];

  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      lane[i] = D_pop[i*BITS +: BITS];
    end
  end

  // Search starts one past the last grant, so the last winner is checked last.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    arb_found = 1'b0;
    arb_id    = grant_q;
    arb_idx   = grant_q;
    for (int k = 1; k <= drvrs; k++) begin
      arb_idx = ID_W'((int'(grant_q) + k) % drvrs);
      if (!arb_found && pndng[arb_idx]) begin
        arb_found = 1'b1;
        arb_id    = arb_idx;
      end
    end
  end

  assign dest = pkt_q[BITS-1 -: 8];

  always_comb begin
    route_mask = '0;
    route_ok   = 1'b1;
    if (dest == 8'(broadcast)) begin
      route_mask          = '1;
      route_mask[grant_q] = 1'b0;
    end else if (int'(dest) < drvrs) begin
      route_mask[dest[ID_W-1:0]] = 1'b1;
    end else begin
      route_ok = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    pkt_d        = pkt_q;
    mask_d       = mask_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pkt_d   = lane[grant_q];
        state_d = ROUTE;
      end
      ROUTE: begin
        if (route_ok) begin
          mask_d  = route_mask;
          state_d = PUSH;
        end else begin
          if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
          state_d = IDLE;
        end
      end
      PUSH: begin
        if (pkt_count_q != '1) pkt_count_d = pkt_count_q + 1'b1;
        // Re-arbitrating here is what gives one packet every three cycles.
        if (arb_found) begin
          grant_d = arb_id;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= ID_W'(drvrs - 1);
      pkt_q        <= '0;
      mask_q       <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      pkt_q        <= pkt_d;
      mask_q       <= mask_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_comb begin
    pop  = '0;
    push = '0;
    if (state_q == GRANT) pop[grant_q] = 1'b1;
    if (state_q == PUSH)  push = mask_q;
  end

  assign D_push     = {drvrs{pkt_q}};
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Central sequencer for the shared bus between `drvrs` device FIFOs.
- Polls each device's `pndng` and grants the bus round-robin.
- Pops one packet from the granted FIFO, decodes the 8-bit destination ID in the packet MSBs, and pushes the packet into the destination FIFO, or into all other FIFOs for broadcast.
- It is the arbitration/routing core behind the bus generator; the per-device FIFOs and the test environment attach directly to its ports.

Parameters:
- `drvrs`, 4, number of devices on the bus (2..16).
- `BITS`, 16, packet width; `BITS` >= 9. Bits [BITS-1:BITS-8] are the destination ID; the rest is payload.
- `broadcast`, 255, destination ID meaning "all devices except the source".
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `clk`  in  1  bus clock
- `reset`  in  1  synchronous, active-high reset
- `pndng`  in  drvrs  per-device "FIFO has data" flag
- `D_pop`  in  drvrs*BITS  per-device FIFO head data; lane i is bits [i*BITS +: BITS]
- `pop`  out  drvrs  one-hot pop strobe to the source FIFO
- `push`  out  drvrs  push strobe mask to destination FIFOs
- `D_push`  out  drvrs*BITS  packet replicated on every lane
- `busy`  out  1  high whenever state != IDLE
- `grant_id`  out  $clog2(drvrs)  index of the current/last granted device
- `pkt_count`  out  CNT_W  packets delivered (a broadcast counts once)
- `drop_count`  out  CNT_W  packets discarded for an invalid destination

Behaviour:
- Reset values (synchronous, sampled on posedge `clk` with `reset`=1):
  - state=IDLE; `pop`=0; `push`=0; `D_push`=0; `busy`=0.
  - `grant_id`=drvrs-1, so device 0 has first priority.
  - Both counters=0; the packet register is cleared.
- Reset has priority over everything. Asserting it mid-operation abandons the transaction: no `pop`/`push` in the following cycle, and the packet is lost.
- Arbitration (evaluated in IDLE and in PUSH):
  - Search `pndng` starting at `grant_id`+1 modulo drvrs, wrapping.
  - The first set bit becomes the new `grant_id`; next state is GRANT.
  - If no bit is set, next state is IDLE and `grant_id` holds.
- GRANT (1 cycle):
  - `pop[grant_id]`=1, all other `pop` bits 0.
  - Lane `grant_id` of `D_pop` is captured into the packet register on this edge.
  - The FIFO presents valid head data while `pndng`=1. `pndng` is not re-checked here.
- ROUTE (1 cycle, all strobes 0). Let dest = pkt[BITS-1:BITS-8].
  - dest == `broadcast`: push mask = all ones except bit `grant_id`. If drvrs=1 the mask would be empty; that case is excluded by the parameter range.
  - dest < drvrs: push mask = one-hot(dest). A self-addressed packet (dest == `grant_id`) is delivered back to the source.
  - Otherwise: `drop_count`++ (saturating at all ones); next state is IDLE; no push.
- PUSH (1 cycle):
  - `push` = mask; `D_push` = packet on all lanes (lanes are driven in every state with the packet register contents).
  - `pkt_count`++ (saturating).
  - Arbitration is evaluated in the same cycle, allowing back-to-back transactions.
- Latency: `pndng` seen in IDLE at cycle 0 → `pop` at cycle 1 → `push` at cycle 3.
- Throughput: one packet every 3 cycles under continuous load.
- Fairness: a device that has just been granted has lowest priority on the next arbitration. With all `pndng` high, grants cycle 0,1,…,drvrs-1,0…
- No destination backpressure: destination FIFOs are sized by the environment. An overflow there is not this block's concern.
- `pndng` dropping between IDLE and GRANT is illegal (the FIFO cannot lose data without a pop). Assert-check it in the bench.

Test Plan (drvrs=4, BITS=16, broadcast=255):
1. Reset, then `pndng`=0010, `D_pop` lane1=16'h03A5.
   → `pop`=0010 in cycle 1.
   → `push`=1000 with `D_push` lanes=16'h03A5 in cycle 3.
   → `pkt_count`=1, `grant_id`=1.
2. `pndng`=1111 held and every lane dest=0.
   → grant order is 0,1,2,3,0, with `pop` strobes exactly 3 cycles apart.
   → `pkt_count`=5 after 5 transactions.
3. Lane2 packet 16'hFF7E.
   → `push`=1011 (all except the source), single cycle.
   → `pkt_count` increments by 1.
4. Lane0 packet 16'h0911 (dest 9 ≥ 4).
   → `pop`=0001, then no `push`.
   → `drop_count`=1, `pkt_count` unchanged, back to IDLE with `busy`=0.
5. Assert `reset` during ROUTE.
   → next cycle: `push`=0, `pop`=0, `busy`=0, counters=0, `grant_id`=3.
   → the next `pndng`=1111 grants device 0 first.
6. Self-addressed lane3 packet 16'h0301.
   → `push`=1000.
   → Force `drop_count` to all ones, then send an invalid packet: the counter stays at 16'hFFFF.
